seg_display_scheduler: RTL

//  Owns the 4-digit seven-segment display and shares it between three sources:

---
 rtl/seg_display_scheduler_pkg.sv | 27 ++
 rtl/seg_display_scheduler_seg_decode.sv | 29 ++
 rtl/seg_display_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Used by the scheduler top and the reusable seg_decode block.
package seg_display_scheduler_pkg;

    typedef enum logic [1:0] {
        SHOW_STATUS = 2'd0,
        SHOW_MSG    = 2'd1,
        SHOW_ALERT  = 2'd2
    } state_e;

    localparam logic [1:0] SRC_STATUS = 2'd0;
    localparam logic [1:0] SRC_MSG    = 2'd1;
    localparam logic [1:0] SRC_ALERT  = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [1:0] state_to_src(input state_e s);
        case (s)
            SHOW_STATUS: return SRC_STATUS;
            SHOW_MSG:    return SRC_MSG;
            SHOW_ALERT:  return SRC_ALERT;
            default:     return SRC_STATUS;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scheduler_seg_decode.sv
// Nibble to active-low segment pattern {g,f,e,d,c,b,a}: 0-9, 'A' as dash,
// everything else blank.
module seg_decode
    import seg_display_scheduler_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Segment lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = SEG_DASH;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit display between live status, messages and alerts, and scans it
// with per-slot blanking and frame-boundary content latching. SEG_DIM_EN adds the dim port.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] status_nums,
    input  logic        msg_req,
    input  logic [15:0] msg_nums,
    output logic        msg_ack,
    input  logic        alert_req,
    input  logic [15:0] alert_nums,
    output logic        alert_ack,
    output logic        busy,
    output logic [1:0]  active_src,
`ifdef SEG_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic [6:0]  display,
    output logic [3:0]  digit
);

    localparam int                  TW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0]       HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [SCAN_DIV-1:0] BLANK_LIM = SCAN_DIV'(BLANK_CYCLES);
    localparam logic [SCAN_DIV-1:0] PRESC_MAX = {SCAN_DIV{1'b1}};

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [15:0]         word_q, word_d;
    logic [15:0]         frame_q, frame_d;
    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [1:0]          idx_q, idx_d;
    logic                msg_ack_q, msg_ack_d;
    logic                alert_ack_q, alert_ack_d;
    logic                busy_q;
    logic [1:0]          src_q;
    logic [6:0]          display_q, display_d;
    logic [3:0]          digit_q, digit_d;
    logic [15:0]         owner_word_s;
    logic [3:0]          nibble_s;
    logic [6:0]          seg_s;
    logic                lit_s;
    logic                alert_go_s, msg_go_s;

    assign owner_word_s = (state_q == SHOW_STATUS) ? status_nums : word_q;
    // A request seen while its own ack is high is the tail of the one just accepted
    assign alert_go_s   = alert_req && !alert_ack_q;
    assign msg_go_s     = msg_req && !msg_ack_q;

    // Ownership FSM: accept, hold timer, alert preemption and reload
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        word_d      = word_q;
        msg_ack_d   = 1'b0;
        alert_ack_d = 1'b0;
        if (alert_go_s) begin
            state_d     = SHOW_ALERT;
            timer_d     = HOLD_LOAD;
            word_d      = alert_nums;
            alert_ack_d = 1'b1;
        end else begin
            case (state_q)
                SHOW_STATUS: begin
                    if (msg_go_s) begin
                        state_d   = SHOW_MSG;
                        timer_d   = HOLD_LOAD;
                        word_d    = msg_nums;
                        msg_ack_d = 1'b1;
                    end else begin
                        state_d = SHOW_STATUS;
                    end
                end
                SHOW_MSG, SHOW_ALERT: begin
                    if (timer_q == {TW{1'b0}}) begin
                        state_d = SHOW_STATUS;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = SHOW_STATUS;
            endcase
        end
    end

    // Scan counters and tear-free frame latch at the digit 3 -> 0 wrap
    always_comb begin
        presc_d = presc_q + SCAN_DIV'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        if (presc_q == PRESC_MAX) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                frame_d = owner_word_s;
            end else begin
                frame_d = frame_q;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    assign nibble_s = frame_d[{idx_d, 2'b00} +: 4];

    seg_decode u_seg_decode (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Pin drive computed from next-state scan position so the registered pins line up
    always_comb begin
`ifdef SEG_DIM_EN
        lit_s = (presc_d >= BLANK_LIM) && (presc_d[SCAN_DIV-1 -: 2] <= dim);
`else
        lit_s = (presc_d >= BLANK_LIM);
`endif
        if (lit_s) begin
            digit_d   = ~(4'b0001 << idx_d);
            display_d = seg_s;
        end else begin
            digit_d   = 4'b1111;
            display_d = SEG_BLANK;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SHOW_STATUS;
            timer_q     <= {TW{1'b0}};
            word_q      <= 16'h0000;
            frame_q     <= 16'h0000;
            presc_q     <= {SCAN_DIV{1'b0}};
            idx_q       <= 2'd0;
            msg_ack_q   <= 1'b0;
            alert_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            src_q       <= SRC_STATUS;
            display_q   <= SEG_BLANK;
            digit_q     <= 4'b1111;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            word_q      <= word_d;
            frame_q     <= frame_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            msg_ack_q   <= msg_ack_d;
            alert_ack_q <= alert_ack_d;
            busy_q      <= (state_d != SHOW_STATUS);
            src_q       <= state_to_src(state_d);
            display_q   <= display_d;
            digit_q     <= digit_d;
        end
    end

    assign msg_ack    = msg_ack_q;
    assign alert_ack  = alert_ack_q;
    assign busy       = busy_q;
    assign active_src = src_q;
    assign display    = display_q;
    assign digit      = digit_q;

endmodule
